// File: rtl/ldpc_cyclic_shifter.sv
// Pipelined runtime-configurable cyclic shifter for QC-LDPC lift sizes up to MAXZ.
// A prep register masks the word to Z bits, folds a left rotate into a right rotate, and
// duplicates the word at offset Z. A log shifter then rotates it, LEVELS_PER_STAGE mux
// levels per register. All stages advance together on a single global enable.
module ldpc_cyclic_shifter #(
  parameter int unsigned MAXZ             = 81,
  parameter int unsigned LEVELS_PER_STAGE = 1,
  parameter int unsigned TAG_W            = 8
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MAXZ-1:0]           in_data,
  input  logic [$clog2(MAXZ+1)-1:0] z_val,
  input  logic [$clog2(MAXZ)-1:0]   shift_val,
  input  logic                      dir_left,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MAXZ-1:0]           out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      out_err
);

  localparam int unsigned L  = $clog2(MAXZ);
  localparam int unsigned ZW = $clog2(MAXZ + 1);
  localparam int unsigned SW = L;
  localparam int unsigned NS = (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
  localparam int unsigned DW = 2 * MAXZ;
  localparam int unsigned PW = NS * LEVELS_PER_STAGE;

  // Index 0 is the prep register; index NS of the valid/err/tag arrays is the output register.
  logic             vld_q  [NS+1];
  logic             vld_d  [NS+1];
  logic             err_q  [NS+1];
  logic             err_d  [NS+1];
  logic [TAG_W-1:0] tag_q  [NS+1];
  logic [TAG_W-1:0] tag_d  [NS+1];
  logic [DW-1:0]    dup_q  [NS];
  logic [DW-1:0]    dup_d  [NS];
  logic [SW-1:0]    sft_q  [NS];
  logic [SW-1:0]    sft_d  [NS];
  logic [MAXZ-1:0]  mask_q [NS];
  logic [MAXZ-1:0]  mask_d [NS];
  logic [MAXZ-1:0]  out_data_q, out_data_d;

  logic             en;
  logic [ZW-1:0]    shift_ext;
  logic             err_p;
  logic [MAXZ-1:0]  mask_p;
  logic [MAXZ-1:0]  m_p;

  // Apply the mux levels owned by stage group grp; level k shifts right by 2^k when s[k] is set.
  function automatic logic [DW-1:0] shift_levels(input logic [DW-1:0] d, input logic [SW-1:0] s,
                                                 input int unsigned grp);
    logic [PW-1:0] sx;
    logic [PW-1:0] bsel;
    logic [DW-1:0] r;
    sx = PW'(s);
    r  = d;
    for (int unsigned lv = 0; lv < LEVELS_PER_STAGE; lv++) begin
      bsel = sx >> (grp * LEVELS_PER_STAGE + lv);
      if (bsel[0]) r = r >> (1 << (grp * LEVELS_PER_STAGE + lv));
    end
    return r;
  endfunction

  assign out_valid = vld_q[NS];
  assign out_err   = err_q[NS];
  assign out_tag   = tag_q[NS];
  assign out_data  = out_data_q;
  // Stalls only when the output holds a beat nobody takes; combinational from out_ready.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

  // Beat legality check and Z-masking of the incoming word.
  always_comb begin
    shift_ext = ZW'(shift_val);
    err_p     = (z_val == '0) || (z_val > ZW'(MAXZ)) || (shift_ext >= z_val);
    mask_p    = ~({MAXZ{1'b1}} << z_val);
    m_p       = in_data & mask_p;
  end

  // Next state for every pipeline register.
  always_comb begin
    vld_d[0]  = in_valid;
    err_d[0]  = in_valid && err_p;
    tag_d[0]  = in_valid ? in_tag : '0;
    mask_d[0] = '0;
    dup_d[0]  = '0;
    sft_d[0]  = '0;
    // Illegal beats and bubbles carry a zero word so they emerge as zero data.
    if (in_valid && !err_p) begin
      mask_d[0] = mask_p;
      dup_d[0]  = {{MAXZ{1'b0}}, m_p} | ({{MAXZ{1'b0}}, m_p} << z_val);
      sft_d[0]  = (dir_left && shift_val != '0) ? SW'(z_val - shift_ext) : shift_val;
    end
    for (int unsigned st = 1; st < NS; st++) begin
      dup_d[st]  = shift_levels(dup_q[st-1], sft_q[st-1], st - 1);
      sft_d[st]  = sft_q[st-1];
      mask_d[st] = mask_q[st-1];
    end
    for (int unsigned st = 1; st <= NS; st++) begin
      vld_d[st] = vld_q[st-1];
      err_d[st] = err_q[st-1];
      tag_d[st] = tag_q[st-1];
    end
    out_data_d = MAXZ'(shift_levels(dup_q[NS-1], sft_q[NS-1], NS - 1)) & mask_q[NS-1];
  end

  // Pipeline registers: synchronous clear, otherwise advance together on the global enable.
  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int unsigned st = 0; st <= NS; st++) begin
        vld_q[st] <= 1'b0;
        err_q[st] <= 1'b0;
        tag_q[st] <= '0;
      end
      for (int unsigned st = 0; st < NS; st++) begin
        dup_q[st]  <= '0;
        sft_q[st]  <= '0;
        mask_q[st] <= '0;
      end
      out_data_q <= '0;
    end else if (en) begin
      for (int unsigned st = 0; st <= NS; st++) begin
        vld_q[st] <= vld_d[st];
        err_q[st] <= err_d[st];
        tag_q[st] <= tag_d[st];
      end
      for (int unsigned st = 0; st < NS; st++) begin
        dup_q[st]  <= dup_d[st];
        sft_q[st]  <= sft_d[st];
        mask_q[st] <= mask_d[st];
      end
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_ldpc_cyclic_shifter.sv
// Bench for ldpc_cyclic_shifter: four instances (LPS = 2, 1, 3, 7) against a rotation model.
module tb_ldpc_cyclic_shifter;

  localparam int MAXZ  = 81;
  localparam int TAG_W = 8;
  localparam int ZW    = 7;
  localparam int SW    = 7;
  localparam int NI    = 4;
  localparam int NBEAT = 100;

  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;

  logic [NI-1:0]                 in_valid, in_ready, dir_left, out_valid, out_ready, out_err;
  logic [NI-1:0][MAXZ-1:0]       in_data, out_data;
  logic [NI-1:0][ZW-1:0]         z_val;
  logic [NI-1:0][SW-1:0]         shift_val;
  logic [NI-1:0][TAG_W-1:0]      in_tag, out_tag;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int unsigned LPS = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 3 : 7;
    ldpc_cyclic_shifter #(
      .MAXZ(MAXZ), .LEVELS_PER_STAGE(LPS), .TAG_W(TAG_W)
    ) u_dut (
      .CLK(CLK), .rst(rst),
      .in_valid(in_valid[gi]), .in_ready(in_ready[gi]), .in_data(in_data[gi]),
      .z_val(z_val[gi]), .shift_val(shift_val[gi]), .dir_left(dir_left[gi]),
      .in_tag(in_tag[gi]),
      .out_valid(out_valid[gi]), .out_ready(out_ready[gi]), .out_data(out_data[gi]),
      .out_tag(out_tag[gi]), .out_err(out_err[gi])
    );
  end

  int n_checks, n_fail;

  // Expected-beat FIFOs, one per instance.
  logic [MAXZ-1:0]  exp_data [NI][256];
  logic [TAG_W-1:0] exp_tag  [NI][256];
  logic             exp_err  [NI][256];
  int               wr_p [NI];
  int               rd_p [NI];
  logic             stall_prev [NI];
  logic [MAXZ-1:0]  prev_data  [NI];
  logic [TAG_W-1:0] prev_tag   [NI];
  logic             prev_err   [NI];
  logic             acc        [NI];
  logic             post_rst;

  task automatic check(input string name, input int inst, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h, expected %0h", name, inst, act, exp);
    end
  endtask

  function automatic logic ref_err(input int z, input int s);
    return (z == 0) || (z > MAXZ) || (s >= z);
  endfunction

  // Rotation straight from the index definition.
  function automatic logic [MAXZ-1:0] ref_rot(input logic [MAXZ-1:0] din, input int z, input int s,
                                              input logic left);
    logic [MAXZ-1:0] r;
    r = '0;
    if (ref_err(z, s)) return r;
    for (int j = 0; j < z; j++) r[j] = din[left ? ((j - s + z) % z) : ((j + s) % z)];
    return r;
  endfunction

  // Compare all instances against the model; runs once per cycle at the falling edge.
  task automatic monitor();
    int idx;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        rd_p[i] = wr_p[i];
        stall_prev[i] = 1'b0;
        acc[i] = 1'b0;
      end
      post_rst = 1'b1;
      return;
    end
    for (int i = 0; i < NI; i++) begin
      if (post_rst) begin
        check("rst_out_valid", i, out_valid[i], 0);
        check("rst_out_data", i, out_data[i], 0);
        check("rst_in_ready", i, in_ready[i], 1);
      end
      check("in_ready", i, in_ready[i], !out_valid[i] || out_ready[i]);
      if (stall_prev[i])
        check("stall_hold", i, {out_valid[i], out_err[i], out_tag[i], out_data[i]},
              {1'b1, prev_err[i], prev_tag[i], prev_data[i]});
      if (rd_p[i] == wr_p[i]) begin
        check("no_spurious", i, out_valid[i], 0);
      end else if (out_valid[i]) begin
        idx = rd_p[i] % 256;
        check("data", i, out_data[i], exp_data[i][idx]);
        check("tag", i, out_tag[i], exp_tag[i][idx]);
        check("err", i, out_err[i], exp_err[i][idx]);
        if (out_ready[i]) rd_p[i]++;
      end
      acc[i] = in_valid[i] && in_ready[i];
      if (acc[i]) begin
        idx = wr_p[i] % 256;
        exp_err[i][idx]  = ref_err(int'(z_val[i]), int'(shift_val[i]));
        exp_data[i][idx] = ref_rot(in_data[i], int'(z_val[i]), int'(shift_val[i]), dir_left[i]);
        exp_tag[i][idx]  = in_tag[i];
        wr_p[i]++;
      end
      stall_prev[i] = out_valid[i] && !out_ready[i];
      prev_data[i]  = out_data[i];
      prev_tag[i]   = out_tag[i];
      prev_err[i]   = out_err[i];
    end
    post_rst = 1'b0;
  endtask

  task automatic tick();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
  endtask

  // Single beat on instance 0 with literal expectations, latency counted in clock edges.
  task automatic send0(input string name, input int z, input int s, input logic left,
                       input logic [MAXZ-1:0] d, input logic [TAG_W-1:0] tag,
                       input logic [MAXZ-1:0] exp_d, input logic exp_e);
    int n;
    in_valid[0]  = 1'b1;
    z_val[0]     = ZW'(z);
    shift_val[0] = SW'(s);
    dir_left[0]  = left;
    in_data[0]   = d;
    in_tag[0]    = tag;
    tick();
    in_valid[0] = 1'b0;
    n = 1;
    while (!out_valid[0] && n < 20) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 0, n, 5);
    check({name, "_data"}, 0, out_data[0], exp_d);
    check({name, "_tag"}, 0, out_tag[0], tag);
    check({name, "_err"}, 0, out_err[0], exp_e);
    tick();
  endtask

  task automatic new_beat(input int i);
    int z;
    logic [95:0] r;
    case ($urandom_range(4, 0))
      0:       z = 1;
      1:       z = 27;
      2:       z = 54;
      3:       z = 81;
      default: z = $urandom_range(81, 1);
    endcase
    z_val[i]     = ZW'(z);
    shift_val[i] = SW'($urandom_range(z - 1, 0));
    if ($urandom_range(19, 0) == 0) shift_val[i] = SW'(z);
    dir_left[i]  = 1'($urandom_range(1, 0));
    r            = {$urandom, $urandom, $urandom};
    in_data[i]   = r[MAXZ-1:0];
    in_tag[i]    = 8'($urandom);
  endtask

  initial begin
    int sent [NI];
    int base [NI];
    int cyc;
    logic busy;
    n_checks = 0;
    n_fail   = 0;
    post_rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      wr_p[i] = 0;
      rd_p[i] = 0;
      stall_prev[i] = 1'b0;
      acc[i] = 1'b0;
      sent[i] = 0;
    end
    rst = 1'b1;
    in_valid = '0; out_ready = '1; in_data = '0; z_val = '0; shift_val = '0;
    dir_left = '0; in_tag = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Directed beats on the LPS = 2 instance.
    send0("right_z27_s1", 27, 1, 1'b0, MAXZ'(1), 8'hA5, MAXZ'(1) << 26, 1'b0);
    send0("left_z54_s53", 54, 53, 1'b1, MAXZ'(1) << 53, 8'h3C, MAXZ'(1) << 52, 1'b0);
    send0("left_z54_s0", 54, 0, 1'b1, MAXZ'(1) << 53, 8'h3D, MAXZ'(1) << 53, 1'b0);
    send0("mask_z27_s5", 27, 5, 1'b0, '1, 8'h5A, MAXZ'(27'h7FF_FFFF), 1'b0);
    send0("err_s_eq_z", 27, 27, 1'b0, '1, 8'h11, '0, 1'b1);
    send0("err_z0", 0, 0, 1'b0, '1, 8'h22, '0, 1'b1);
    send0("err_z82", 82, 0, 1'b0, '1, 8'h33, '0, 1'b1);
    send0("legal_after_err", 27, 3, 1'b0, MAXZ'(1), 8'h44, MAXZ'(1) << 24, 1'b0);
    send0("z1_identity", 1, 0, 1'b1, '1, 8'h55, MAXZ'(1), 1'b0);

    // Random streams on all instances with random gaps and backpressure.
    for (int i = 0; i < NI; i++) base[i] = rd_p[i];
    busy = 1'b1;
    cyc  = 0;
    while (busy && cyc < 5000) begin
      busy = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (!in_valid[i] || acc[i]) begin
          if (sent[i] < NBEAT && $urandom_range(3, 0) != 0) begin
            new_beat(i);
            in_valid[i] = 1'b1;
            sent[i]++;
          end else begin
            in_valid[i] = 1'b0;
          end
        end
        out_ready[i] = 1'($urandom_range(1, 0));
        if (sent[i] < NBEAT || in_valid[i]) busy = 1'b1;
      end
      if (busy) begin
        tick();
        cyc++;
      end
    end
    check("stream_done", 0, busy, 0);
    in_valid  = '0;
    out_ready = '1;
    repeat (30) tick();
    for (int i = 0; i < NI; i++) begin
      check("drained", i, wr_p[i] - rd_p[i], 0);
      check("beats_out", i, rd_p[i] - base[i], NBEAT);
    end

    // Reset while instance 0 is stalled with several beats in flight.
    out_ready = '0;
    for (int k = 0; k < 6; k++) begin
      if (!in_valid[0] || acc[0]) new_beat(0);
      in_valid[0] = 1'b1;
      tick();
    end
    check("stalled_before_rst", 0, out_valid[0], 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = '0;
    check("rst_valid_now", 0, out_valid[0], 0);
    check("rst_data_now", 0, out_data[0], 0);
    check("rst_tag_now", 0, out_tag[0], 0);
    check("rst_err_now", 0, out_err[0], 0);
    check("rst_ready_now", 0, in_ready[0], 1);
    out_ready = '1;
    repeat (20) tick();
    send0("left_z81_s1", 81, 1, 1'b1, MAXZ'(1), 8'h66, MAXZ'(2), 1'b0);
    send0("right_z81_s80", 81, 80, 1'b0, MAXZ'(1), 8'h77, MAXZ'(2), 1'b0);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ldpc_cyclic_shifter.md
# ldpc_cyclic_shifter

Runtime-configurable, fully pipelined cyclic shifter for the QC-LDPC datapath. It rotates the low `z_val` bits of a `MAXZ`-wide word by `shift_val` positions, right or left, with `z_val` and direction chosen per beat. The pipeline has a valid/ready handshake with full backpressure and a configurable number of mux levels per register stage. It sits between the sub-block buffer and the check-node / parity accumulators, so one instance serves every 802.11n lift size (27/54/81).

## Interface
- `MAXZ`, 81: maximum lift size; datapath width.
- `LEVELS_PER_STAGE`, 1: log-shifter mux levels per pipeline register; legal range 1..L, where L = $clog2(MAXZ).
- `TAG_W`, 8: width of the sideband tag carried with each beat.

Ports:
- `CLK` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input accepted when `in_valid && in_ready`.
- `in_data` in MAXZ: data; bits at index ≥ `z_val` are ignored.
- `z_val` in $clog2(MAXZ+1): active lift size Z.
- `shift_val` in $clog2(MAXZ): rotation amount s.
- `dir_left` in 1: 0 = right rotate, 1 = left rotate.
- `in_tag` in TAG_W: sideband, passed through unchanged.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out MAXZ: rotated word; bits ≥ Z are always 0.
- `out_tag` out TAG_W: tag of this beat.
- `out_err` out 1: beat had an illegal Z or shift.

## Operation
- **Right rotate:** out[j] = in[(j+s) mod Z] for j < Z.
- **Left rotate:** out[j] = in[(j−s) mod Z].
- **Prep stage (register P0):**
  - Mask the input to Z bits.
  - Convert a left rotate to a right rotate by s' = (s==0) ? 0 : Z−s.
  - Form the 2·MAXZ-wide duplicate word d = m | (m << Z).
- **Shift stages:** L levels. Level k shifts d right by 2^k when bit k of s' is set. Levels are grouped `LEVELS_PER_STAGE` per register, giving NS = ceil(L / LEVELS_PER_STAGE) registers.
- **Output:** low MAXZ bits of the shifted word, ANDed with the Z-mask. The Z-mask and tag travel down the pipeline alongside the data.
- **Error handling:** if z_val == 0, z_val > MAXZ, or shift_val ≥ z_val, then `out_err` = 1, `out_data` = 0, and the tag still passes. `out_err` is not sticky.
- **Flow control:**
  - Single global enable: en = !out_valid || out_ready.
  - `in_ready` = en.
  - On en, all stages advance together.
  - Each stage carries a valid bit; bubbles are allowed and propagate.
  - No data loss or duplication under any ready pattern.
- **Degenerate cases:**
  - s = 0 gives identity (masked to Z).
  - Z = 1 gives out[0] = in[0] for any legal s (s must be 0).
  - Z = MAXZ must work for all s < MAXZ.

## Timing
- Latency is 1 + NS cycles from accept to `out_valid`, with no stall.
  - MAXZ = 81, LPS = 1: 8 cycles.
  - MAXZ = 81, LPS = 2: 5 cycles.
  - MAXZ = 81, LPS = 7: 2 cycles.
- Throughput: one beat per cycle while `out_ready` = 1.
- While out_valid && !out_ready, every stage holds and `in_ready` = 0 in that same cycle (combinational from `out_ready`).
- `out_*` are stable while stalled.
- **Reset:**
  - Synchronous; all stage valids, `out_valid`, `out_data`, `out_tag` and `out_err` go to 0 on the next edge.
  - In-flight beats are discarded.
  - Reset asserted mid-stall also clears everything.
  - `in_ready` = 1 in the first cycle after reset deasserts.
- Z, direction and shift may change every beat; there is no inter-beat dependency.

## Test plan
- **Basic right rotate.** MAXZ = 81, LPS = 2, Z = 27, right, s = 1, data = 0x1. Expect `out_data` = 1<<26 exactly 5 cycles after accept, with tag echoed.
- **Left rotate and mod-Z wrap.** Z = 54, left, s = 53, data = 1<<53. Expect `out_data` = 1<<52. Same data with s = 0: output is unchanged.
- **Masking.** Z = 27, data = all-ones (81 bits), right, s = 5. Expect `out_data` = 27 ones in bits [26:0] and 0 above.
- **Errors.** (Z = 27, s = 27), (Z = 0, s = 0) and (Z = 82, s = 0). Each gives `out_err` = 1 and `out_data` = 0, and the next legal beat has `out_err` = 0.
- **Backpressure.** Stream 100 random legal beats with random `out_ready` (~50% duty) and random `in_valid` gaps. The output sequence must match a reference model in order, with `out_*` held stable while stalled. Repeat for LPS = 1, 3, 7.
- **Reset mid-operation.** With 4 beats in flight and `out_ready` = 0, assert `rst` for 1 cycle. Next cycle: `out_valid` = 0, `out_data` = 0, `in_ready` = 1. No stale beat ever emerges.
